diag_check_detector: RTL and testbench

- Sequential controller that sits directly downstream of the diagonal ray scanner.
- Per request: steps the scanner through all four diagonal directions from a king square, validates each returned nearest-piece result against the board, and reports whether that king is attacked along a diagonal.
- Diagonal attackers: bishop, queen, or a pawn of the opposite colour.
- Consumer is the move-legality/check logic.

---
 rtl/diag_check_detector_if.sv | 27 ++
 rtl/diag_check_detector.sv | 135 +++++++++++++
 tb/tb_diag_check_detector.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/diag_check_detector_if.sv
// Request/result and scanner signals shared by the diagonal check detector and its
// surroundings (check logic on one side, diagonal ray scanner on the other).
interface diag_check_detector_if;
    logic         start;
    logic [5:0]   king_pos;
    logic         king_color;
    logic [255:0] big_board;
    logic [1:0]   scan_dir;
    logic [5:0]   scan_origin;
    logic [5:0]   scan_near_pos;
    logic [2:0]   scan_near_piece;
    logic         busy;
    logic         done;
    logic         in_check;
    logic [3:0]   attack_mask;
    logic [5:0]   attacker_pos;

    modport slave (
        input  start, king_pos, king_color, big_board, scan_near_pos, scan_near_piece,
        output scan_dir, scan_origin, busy, done, in_check, attack_mask, attacker_pos
    );

    modport master (
        output start, king_pos, king_color, big_board, scan_near_pos, scan_near_piece,
        input  scan_dir, scan_origin, busy, done, in_check, attack_mask, attacker_pos
    );
endinterface

// File: rtl/diag_check_detector.sv
// Steps the diagonal ray scanner through all four directions from a latched king square
// and flags bishops, queens and correctly-facing enemy pawns that attack the king.
module diag_check_detector #(
    parameter int SCAN_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    diag_check_detector_if.slave bus,
    output logic [2:0]           dbg_state
);
    // Handshake: start is sampled only in IDLE; busy is high from the accept edge until
    // the edge that raises done; done is a one-cycle strobe with results valid, and the
    // results hold until the next accept.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] WAIT_LOAD = (SCAN_LATENCY >= 2) ? 3'(SCAN_LATENCY - 2) : 3'd0;

    state_t       state;
    logic [1:0]   dir;
    logic [2:0]   wait_cnt;
    logic [5:0]   king;
    logic         color;
    logic [255:0] board;

    logic [3:0]   dr;
    logic [3:0]   dc;
    logic [3:0]   adr;
    logic [3:0]   adc;
    logic [3:0]   nib;
    logic         geom_ok;
    logic         sign_ok;
    logic         type_ok;
    logic         valid_hit;
    logic         slider;
    logic         pawn_hit;
    logic         is_attacker;

    assign dbg_state = state;

    // Differences are 4-bit two's complement; bit 3 is the sign. Direction bit 0 means
    // row increases, bit 1 means column increases.
    always_comb begin
        dr          = {1'b0, bus.scan_near_pos[5:3]} - {1'b0, king[5:3]};
        dc          = {1'b0, bus.scan_near_pos[2:0]} - {1'b0, king[2:0]};
        adr         = dr[3] ? (4'd0 - dr) : dr;
        adc         = dc[3] ? (4'd0 - dc) : dc;
        nib         = board[{bus.scan_near_pos, 2'b00} +: 4];
        geom_ok     = (dr != 4'd0) && (adr == adc);
        sign_ok     = (dr[3] == ~dir[0]) && (dc[3] == ~dir[1]);
        type_ok     = (nib[2:0] != 3'b000) && (nib[2:0] == bus.scan_near_piece);
        valid_hit   = geom_ok && sign_ok && type_ok;
        slider      = (nib[2:0] == 3'b011) || (nib[2:0] == 3'b101);
        pawn_hit    = (nib[2:0] == 3'b001) && (adr == 4'd1) && (dir[0] == color);
        is_attacker = valid_hit && (nib[3] != color) && (slider || pawn_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            dir              <= 2'd0;
            wait_cnt         <= 3'd0;
            king             <= 6'd0;
            color            <= 1'b0;
            board            <= '0;
            bus.scan_dir     <= 2'd0;
            bus.scan_origin  <= 6'd0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.in_check     <= 1'b0;
            bus.attack_mask  <= 4'd0;
            bus.attacker_pos <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        king             <= bus.king_pos;
                        color            <= bus.king_color;
                        board            <= bus.big_board;
                        dir              <= 2'd0;
                        bus.scan_dir     <= 2'd0;
                        bus.scan_origin  <= bus.king_pos;
                        bus.busy         <= 1'b1;
                        bus.in_check     <= 1'b0;
                        bus.attack_mask  <= 4'd0;
                        bus.attacker_pos <= 6'd0;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= (SCAN_LATENCY >= 2) ? WAIT : EVAL;
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= EVAL;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                EVAL: begin
                    if (is_attacker) begin
                        bus.attack_mask[dir] <= 1'b1;
                        // Directions run in ascending order, so the first hit is the lowest.
                        if (bus.attack_mask == 4'd0) begin
                            bus.attacker_pos <= bus.scan_near_pos;
                        end
                    end
                    if (dir == 2'd3) begin
                        state <= DONE;
                    end else begin
                        dir          <= dir + 2'd1;
                        bus.scan_dir <= dir + 2'd1;
                        state        <= ISSUE;
                    end
                end
                DONE: begin
                    bus.in_check <= |bus.attack_mask;
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_diag_check_detector.sv
// Directed bench for diag_check_detector: a pipelined scanner model feeds table-driven
// responses, and done results are checked against a queue of expected outcomes.
module tb_diag_check_detector;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    diag_check_detector_if bus ();
    diag_check_detector_if bus4 ();
    logic [2:0] dbg_state;
    logic [2:0] dbg_state4;

    diag_check_detector #(.SCAN_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .dbg_state(dbg_state)
    );
    diag_check_detector #(.SCAN_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave), .dbg_state(dbg_state4)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t_acc = 0;
    int t_acc4 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scanner model: response tables indexed by the direction seen SCAN_LATENCY cycles ago.
    logic [5:0]   resp_pos[4];
    logic [2:0]   resp_piece[4];
    logic [1:0]   p2[2];
    logic [1:0]   p4[4];
    logic [255:0] board_v;

    always @(posedge clk) begin
        p2[0] <= bus.scan_dir;
        p2[1] <= p2[0];
        p4[0] <= bus4.scan_dir;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign bus.scan_near_pos    = resp_pos[p2[1]];
    assign bus.scan_near_piece  = resp_piece[p2[1]];
    assign bus4.scan_near_pos   = resp_pos[p4[3]];
    assign bus4.scan_near_piece = resp_piece[p4[3]];

    // Expected entry: {latency[7:0], in_check, attack_mask[3:0], attacker_pos[5:0]}
    logic [18:0] exp_q[$];
    logic [18:0] exp4_q[$];
    logic [18:0] got0, want0, got4, want4;

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            got0 = {8'(cyc - t_acc), bus.in_check, bus.attack_mask, bus.attacker_pos};
            want0 = '1;
            if (exp_q.size() != 0) want0 = exp_q.pop_front();
            n_cmp++;
            assert (got0 === want0) else begin
                n_err++;
                $error("FAIL done_l2 got lat=%0d chk=%b mask=%b pos=%0d exp lat=%0d chk=%b mask=%b pos=%0d",
                       got0[18:11], got0[10], got0[9:6], got0[5:0],
                       want0[18:11], want0[10], want0[9:6], want0[5:0]);
            end
            n_cmp++;
            assert (bus.busy === 1'b0) else begin
                n_err++;
                $error("FAIL busy_at_done_l2 got %b exp 0", bus.busy);
            end
        end
        if (!reset && bus4.done) begin
            got4 = {8'(cyc - t_acc4), bus4.in_check, bus4.attack_mask, bus4.attacker_pos};
            want4 = '1;
            if (exp4_q.size() != 0) want4 = exp4_q.pop_front();
            n_cmp++;
            assert (got4 === want4) else begin
                n_err++;
                $error("FAIL done_l4 got lat=%0d chk=%b mask=%b pos=%0d exp lat=%0d chk=%b mask=%b pos=%0d",
                       got4[18:11], got4[10], got4[9:6], got4[5:0],
                       want4[18:11], want4[10], want4[9:6], want4[5:0]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s got %0h exp %0h", tag, act, exp);
        end
    endtask

    task automatic clear_setup(input logic [5:0] k);
        board_v = '0;
        for (int d = 0; d < 4; d++) begin
            resp_pos[d]   = k;
            resp_piece[d] = 3'b000;
        end
    endtask

    task automatic put(input int sq, input logic [3:0] nib);
        board_v[sq*4 +: 4] = nib;
    endtask

    task automatic set_resp(input int d, input logic [5:0] p, input logic [2:0] t);
        resp_pos[d]   = p;
        resp_piece[d] = t;
    endtask

    task automatic scramble(input bit sel);
        for (int i = 0; i < 8; i++) begin
            if (sel) bus4.big_board[i*32 +: 32] = $urandom();
            else     bus.big_board[i*32 +: 32]  = $urandom();
        end
        if (sel) begin
            bus4.king_pos   = 6'($urandom_range(0, 63));
            bus4.king_color = ~bus4.king_color;
        end else begin
            bus.king_pos    = 6'($urandom_range(0, 63));
            bus.king_color  = ~bus.king_color;
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus4.start = v;
        else     bus.start  = v;
    endtask

    task automatic drive_start(input bit sel, input logic [5:0] k, input logic c);
        @(negedge clk);
        if (sel) begin
            bus4.king_pos = k; bus4.king_color = c; bus4.big_board = board_v;
        end else begin
            bus.king_pos = k; bus.king_color = c; bus.big_board = board_v;
        end
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        if (sel) t_acc4 = cyc;
        else     t_acc  = cyc;
        set_start(sel, 1'b0);
        scramble(sel);
    endtask

    task automatic run_case(input string tag, input bit sel, input logic [5:0] k,
                            input logic c, input logic [18:0] exp);
        int pend;
        if (sel) exp4_q.push_back(exp);
        else     exp_q.push_back(exp);
        drive_start(sel, k, c);
        @(negedge clk);
        chk({tag, "_busy"},   sel ? 32'(bus4.busy)        : 32'(bus.busy),        32'd1);
        chk({tag, "_origin"}, sel ? 32'(bus4.scan_origin) : 32'(bus.scan_origin), 32'(k));
        chk({tag, "_dir0"},   sel ? 32'(bus4.scan_dir)    : 32'(bus.scan_dir),    32'd0);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        pend = 1;
        for (int i = 0; i < 80 && pend != 0; i++) begin
            @(negedge clk);
            pend = sel ? exp4_q.size() : exp_q.size();
        end
        chk({tag, "_pending"}, 32'(pend), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_hold_mask"}, sel ? 32'(bus4.attack_mask) : 32'(bus.attack_mask), 32'(exp[9:6]));
        chk({tag, "_hold_chk"},  sel ? 32'(bus4.in_check)    : 32'(bus.in_check),    32'(exp[10]));
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;  bus.king_pos = 6'd0;  bus.king_color = 1'b0;  bus.big_board = '0;
        bus4.start = 1'b0; bus4.king_pos = 6'd0; bus4.king_color = 1'b0; bus4.big_board = '0;
        clear_setup(6'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   32'(bus.busy),         32'd0);
        chk("rst_done",   32'(bus.done),         32'd0);
        chk("rst_mask",   32'(bus.attack_mask),  32'd0);
        chk("rst_pos",    32'(bus.attacker_pos), 32'd0);
        chk("rst_state",  32'(dbg_state),        32'd0);
        chk("rst4_busy",  32'(bus4.busy),        32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: black bishop at 0 attacks white king 36 along dir 00
        clear_setup(6'd36); put(0, 4'b1011); set_resp(0, 6'd0, 3'b011);
        run_case("t1_bishop", 1'b0, 6'd36, 1'b0, {8'd13, 1'b1, 4'b0001, 6'd0});

        // 2: own pawn at 27 blocks
        clear_setup(6'd36); put(0, 4'b1011); put(27, 4'b0001); set_resp(0, 6'd27, 3'b001);
        run_case("t2_block", 1'b0, 6'd36, 1'b0, {8'd13, 1'b0, 4'b0000, 6'd0});

        // 3: black pawns at 27 (attacks) and 45 (faces away)
        clear_setup(6'd36); put(27, 4'b1001); put(45, 4'b1001);
        set_resp(0, 6'd27, 3'b001); set_resp(3, 6'd45, 3'b001);
        run_case("t3_pawns", 1'b0, 6'd36, 1'b0, {8'd13, 1'b1, 4'b0001, 6'd27});

        // 4: black king in corner, stale dir 00 response, white queen at 63
        clear_setup(6'd0); put(63, 4'b0101);
        set_resp(0, 6'd36, 3'b101); set_resp(3, 6'd63, 3'b101);
        run_case("t4_corner", 1'b0, 6'd0, 1'b1, {8'd13, 1'b1, 4'b1000, 6'd63});

        // 7: white king on edge square 7; bishop at 14 reported for every direction
        clear_setup(6'd7); put(14, 4'b1011);
        for (int d = 0; d < 4; d++) set_resp(d, 6'd14, 3'b011);
        run_case("t7_edge", 1'b0, 6'd7, 1'b0, {8'd13, 1'b1, 4'b0010, 6'd14});

        // 8: black king 36; white pawns at 27 (wrong side) and 43 (attacks); type mismatch at 22
        clear_setup(6'd36); put(27, 4'b0001); put(43, 4'b0001); put(22, 4'b0011);
        set_resp(0, 6'd27, 3'b001); set_resp(1, 6'd43, 3'b001); set_resp(2, 6'd22, 3'b101);
        run_case("t8_wpawn", 1'b0, 6'd36, 1'b1, {8'd13, 1'b1, 4'b0010, 6'd43});

        // 9: two attackers, lowest direction wins attacker_pos
        clear_setup(6'd36); put(0, 4'b1011); put(54, 4'b1101);
        set_resp(0, 6'd0, 3'b011); set_resp(3, 6'd54, 3'b101);
        run_case("t9_multi", 1'b0, 6'd36, 1'b0, {8'd13, 1'b1, 4'b1001, 6'd0});

        // 5: repeated start while busy, then reset at cycle 6 aborts the scan
        clear_setup(6'd36); put(0, 4'b1011); set_resp(0, 6'd0, 3'b011);
        drive_start(1'b0, 6'd36, 1'b0);
        @(negedge clk);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        chk("t5_mask_mid", 32'(bus.attack_mask), 32'd1);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("t5_busy",   32'(bus.busy),         32'd0);
        chk("t5_done",   32'(bus.done),         32'd0);
        chk("t5_chk",    32'(bus.in_check),     32'd0);
        chk("t5_mask",   32'(bus.attack_mask),  32'd0);
        chk("t5_pos",    32'(bus.attacker_pos), 32'd0);
        chk("t5_dir",    32'(bus.scan_dir),     32'd0);
        chk("t5_origin", 32'(bus.scan_origin),  32'd0);
        chk("t5_state",  32'(dbg_state),        32'd0);
        repeat (20) @(negedge clk);
        run_case("t5_rerun", 1'b0, 6'd36, 1'b0, {8'd13, 1'b1, 4'b0001, 6'd0});

        // 6: longer scanner latency, queen at 54 via dir 11
        clear_setup(6'd36); put(54, 4'b1101); set_resp(3, 6'd54, 3'b101);
        run_case("t6_lat4", 1'b1, 6'd36, 1'b0, {8'd21, 1'b1, 4'b1000, 6'd54});

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
